// File: rtl/mpu_fault_handler.sv
// MPU fault handler: captures the first violation, raises irq, counts faults
// and escalates to a sticky lockout. Optional timestamp: MPU_FAULT_TIMESTAMP_EN.
module mpu_fault_handler #(
  parameter int LOCK_THRESHOLD = 8,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        viol_valid,
  input  logic [31:0] viol_addr,
  input  logic        viol_write,
  input  logic        viol_exec,
  input  logic        viol_priv,
  input  logic        reg_sel,
  input  logic        reg_we,
  input  logic [4:0]  reg_addr,
  input  logic [31:0] reg_wdata,
  output logic [31:0] reg_rdata,
  output logic        reg_ready,
  output logic        irq,
  output logic        lockout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FAULT  = 2'd1,
    LOCKED = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [31:0]      addr_q, addr_d;
  logic [2:0]       info_q, info_d;
  logic             ovr_q, ovr_d;
  logic             irq_q, irq_d;
  logic             lock_q, lock_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             ready_q, ready_d;
  logic             ack, cap, lock_hit;
  logic [7:0]       cnt8;
  logic [31:0]      ts_rd;
  logic             unused_wdata;

  assign unused_wdata = ^reg_wdata[31:1];
  assign cnt8 = 8'(cnt_q);

  assign ack = reg_sel & reg_we &
               (reg_addr == 5'h0C) & reg_wdata[0];

  assign cnt_inc = (&cnt_q) ? cnt_q
                            : cnt_q + CNT_W'(1);

  assign lock_hit = viol_valid &
                    (int'(cnt_inc) >= LOCK_THRESHOLD);

`ifdef MPU_FAULT_TIMESTAMP_EN
  logic [31:0] ts_cnt_q, ts_cnt_d;
  logic [31:0] ts_q, ts_d;

  // Free-running cycle counter; snapshot taken on every capture
  always_comb begin
    ts_cnt_d = ts_cnt_q + 32'd1;
    ts_d     = cap ? ts_cnt_q : ts_q;
  end

  // Timestamp state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ts_cnt_q <= '0;
      ts_q     <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_d;
      ts_q     <= ts_d;
    end
  end

  assign ts_rd = ts_q;
`else
  assign ts_rd = '0;
`endif

  // Fault FSM: first fault wins, ACK releases, threshold locks for good
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    info_d  = info_q;
    ovr_d   = ovr_q;
    cap     = 1'b0;
    if (viol_valid) cnt_d = cnt_inc;
    unique case (state_q)
      IDLE: begin
        if (viol_valid) begin
          cap     = 1'b1;
          state_d = lock_hit ? LOCKED : FAULT;
        end
      end
      FAULT: begin
        if (viol_valid && ack) begin
          cap     = 1'b1;
          ovr_d   = 1'b0;
          state_d = lock_hit ? LOCKED : FAULT;
        end else if (viol_valid) begin
          ovr_d   = 1'b1;
          state_d = lock_hit ? LOCKED : FAULT;
        end else if (ack) begin
          ovr_d   = 1'b0;
          state_d = IDLE;
        end
      end
      LOCKED: state_d = LOCKED;
      default: state_d = IDLE;
    endcase
    if (cap) begin
      addr_d = viol_addr;
      info_d = {viol_priv, viol_exec, viol_write};
    end
    irq_d  = (state_d != IDLE);
    lock_d = (state_d == LOCKED);
  end

  // Register read mux; sees pre-capture state
  always_comb begin
    rdata_d = '0;
    ready_d = reg_sel;
    if (reg_sel && !reg_we) begin
      case (reg_addr)
        5'h00: rdata_d = {16'd0, cnt8, 5'd0,
                          state_q == LOCKED,
                          ovr_q,
                          state_q != IDLE};
        5'h04: rdata_d = addr_q;
        5'h08: rdata_d = {29'd0, info_q};
        5'h10: rdata_d = ts_rd;
        default: rdata_d = '0;
      endcase
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      info_q  <= '0;
      ovr_q   <= 1'b0;
      irq_q   <= 1'b0;
      lock_q  <= 1'b0;
      rdata_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      info_q  <= info_d;
      ovr_q   <= ovr_d;
      irq_q   <= irq_d;
      lock_q  <= lock_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
    end
  end

  assign reg_rdata = rdata_q;
  assign reg_ready = ready_q;
  assign irq       = irq_q;
  assign lockout   = lock_q;

endmodule

// File: doc/mpu_fault_handler.md
Name: mpu_fault_handler

Overview:
- Sits on the response side of the memory protection unit. It receives qualified violation events from the MPU and the bus.
- Captures the first fault's address and access type and raises an interrupt to the CPU.
- Counts violations and escalates to a sticky tamper lockout after a configurable number of faults.
- Firmware reads and acknowledges faults through a small register interface.

Parameters:
LOCK_THRESHOLD, 8, violation count (1..255) at which the block enters LOCKED
CNT_W, 8, width of the saturating violation counter

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
viol_valid  input  1  one-cycle pulse: MPU violation on a live bus access
viol_addr  input  32  faulting address
viol_write  input  1  faulting access was a write
viol_exec  input  1  faulting access was an instruction fetch
viol_priv  input  1  CPU was in machine mode at the fault
reg_sel  input  1  register access strobe, one cycle
reg_we  input  1  1 = write, 0 = read
reg_addr  input  5  byte offset: 0x00, 0x04, 0x08, 0x0C, 0x10
reg_wdata  input  32  write data
reg_rdata  output  32  read data, registered
reg_ready  output  1  one-cycle pulse, the cycle after reg_sel
irq  output  1  level interrupt, high while a fault is pending
lockout  output  1  sticky; high in LOCKED, used to gate the key store and lock actuator

Behaviour:
- Interface: one clock; reset is synchronous and active-low. Both are fixed.
- Reset: all outputs are 0, state is IDLE, and all captured fields, overrun and count are 0.
- Reset applied mid-fault or in LOCKED returns the block to IDLE with everything cleared.
- FSM states are IDLE, FAULT and LOCKED.
- IDLE to FAULT on viol_valid:
  - Latch addr and the {priv, exec, write} info.
  - Increment the count.
  - irq is high the next cycle (1-cycle latency).
- While in FAULT, each further viol_valid:
  - Increments the count.
  - Sets overrun=1.
  - Leaves the captured address and info unchanged; the first fault wins.
- FAULT to IDLE on a write of 1 to CTRL bit0 (ACK). This clears pending and overrun; irq drops the next cycle.
- Simultaneous ACK and viol_valid in the same cycle:
  - The new fault is captured.
  - The state stays in FAULT, overrun=0 and irq stays high.
- Any state to LOCKED:
  - Trigger: the count after incrementing is >= LOCK_THRESHOLD.
  - lockout=1 and irq=1 the next cycle.
- LOCKED is terminal until reset:
  - ACK is ignored.
  - Violations still increment the count but capture nothing new.
- The count saturates at 2^CNT_W-1 and never wraps.
- Register map:
  - 0x00 STATUS (RO): bit0 pending, bit1 overrun, bit2 locked, bits[15:8] count.
  - 0x04 FAULT_ADDR (RO).
  - 0x08 FAULT_INFO (RO): bit0 write, bit1 exec, bit2 priv.
  - 0x0C CTRL: write bit0=1 to ACK; reads 0.
  - 0x10 TIMESTAMP, see Optional Feature.
- Register accesses:
  - Unmapped offsets read 0; writes to them are ignored.
  - Writes to RO registers are ignored.
  - reg_ready pulses for every access, mapped or not.
- A read in the same cycle as a capture returns the pre-capture values.

Optional Feature:
- Macro MPU_FAULT_TIMESTAMP_EN.
- When defined:
  - A free-running 32-bit cycle counter starts at 0 on reset and wraps.
  - Its value is latched on each capture into the TIMESTAMP register at 0x10.
- When undefined:
  - There is no counter logic.
  - 0x10 reads 0.

Test Plan:
- Capture: reset, then viol_valid with addr=0x40000010, write=1, exec=0, priv=0 -> next cycle irq=1; STATUS=0x00000101, FAULT_ADDR=0x40000010, FAULT_INFO=0x1.
- Overrun: with a fault pending, pulse a violation at addr=0x00000004 -> FAULT_ADDR unchanged at 0x40000010; STATUS=0x00000203.
- ACK: write CTRL=1 -> next cycle irq=0; STATUS=0x00000200 (count retained); reg_ready pulses 1 cycle after reg_sel.
- Simultaneous: ACK and a violation at 0x00010000 in the same cycle -> irq stays 1; FAULT_ADDR=0x00010000; overrun=0; count +1.
- Lockout: LOCK_THRESHOLD=8, 8 violations -> lockout=1 after the 8th; ACK leaves lockout=1 and irq=1; 300 violations -> count=255; rst_n=0 for one cycle -> all outputs 0.
- Timestamp (macro defined): violation at cycle 100 after reset -> TIMESTAMP reads 100; macro undefined -> 0x10 reads 0.
